// File: rtl/axi_tlb_miss_log.sv
// Logs TLB-miss records (address, AXI ID, direction) into a small circular buffer for software.
// Latency: a record accepted in cycle t is visible at the log head in cycle t+1 (no fall-through).
// Backpressure: DropWhenFull=1 always accepts and counts overflow drops; DropWhenFull=0 stalls the miss path when full.
module axi_tlb_miss_log #(
   parameter int unsigned AddrWidth    = 32,
   parameter int unsigned IdWidth      = 4,
   parameter int unsigned Depth        = 4,
   parameter bit          DropWhenFull = 1'b1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       miss_valid_i,
   output logic                       miss_ready_o,
   input  logic [AddrWidth-1:0]       miss_addr_i,
   input  logic [IdWidth-1:0]         miss_id_i,
   input  logic                       miss_write_i,
   output logic                       log_valid_o,
   input  logic                       log_ready_i,
   output logic [AddrWidth-1:0]       log_addr_o,
   output logic [IdWidth-1:0]         log_id_o,
   output logic                       log_write_o,
   output logic [$clog2(Depth):0]     fill_o,
   output logic [15:0]                drop_cnt_o,
   output logic                       irq_o,
   input  logic                       irq_clear_i
);

   localparam int unsigned PtrW  = $clog2(Depth);
   localparam int unsigned FillW = PtrW + 1;
   localparam logic [FillW-1:0] DepthFill = FillW'(Depth);

   // Entry storage; contents are never reset, only the pointers and fill count qualify them.
   logic [AddrWidth-1:0] r_addr_mem  [Depth];
   logic [IdWidth-1:0]   r_id_mem    [Depth];
   logic                 r_write_mem [Depth];

   logic [PtrW-1:0]  r_wr_ptr;
   logic [PtrW-1:0]  r_rd_ptr;
   logic [FillW-1:0] r_fill;
   logic [15:0]      r_drop_cnt;
   logic             r_irq;

   logic w_full;
   logic w_empty;
   logic w_ready;
   logic w_pop;
   logic w_accept;
   logic w_push;
   logic w_drop;
   logic w_irq_set;

   assign w_full  = (r_fill == DepthFill);
   assign w_empty = (r_fill == '0);

   // Ready never looks at miss_valid_i. In stall mode a full log can still take a record
   // when the consumer pops in the same cycle; during reset the log is treated as empty.
   assign w_ready = DropWhenFull ? 1'b1 : (rst_i || !w_full || log_ready_i);

   assign w_pop     = !w_empty && log_ready_i;
   assign w_accept  = miss_valid_i && w_ready;
   assign w_push    = w_accept && (!w_full || w_pop);
   assign w_drop    = w_accept && w_full && !w_pop;
   assign w_irq_set = (w_push && w_empty) || w_drop;

   assign miss_ready_o = w_ready;
   assign log_valid_o  = !w_empty;
   assign log_addr_o   = r_addr_mem[r_rd_ptr];
   assign log_id_o     = r_id_mem[r_rd_ptr];
   assign log_write_o  = r_write_mem[r_rd_ptr];
   assign fill_o       = r_fill;
   assign drop_cnt_o   = r_drop_cnt;
   assign irq_o        = r_irq;

   // Write the accepted record into the slot at the write pointer.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_addr_mem[r_wr_ptr]  <= miss_addr_i;
         r_id_mem[r_wr_ptr]    <= miss_id_i;
         r_write_mem[r_wr_ptr] <= miss_write_i;
      end
   end

   // Pointers wrap naturally because Depth is a power of two; fill tracks push/pop balance.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PtrW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PtrW'(1);
         end
         if (w_push && !w_pop) begin
            r_fill <= r_fill + FillW'(1);
         end else if (w_pop && !w_push) begin
            r_fill <= r_fill - FillW'(1);
         end
      end
   end

   // Saturating count of records discarded because the log was full.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_drop_cnt <= '0;
      end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
         r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end

   // Sticky interrupt: first entry into an empty log or any drop sets it; set beats clear.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_irq <= 1'b0;
      end else if (w_irq_set) begin
         r_irq <= 1'b1;
      end else if (irq_clear_i) begin
         r_irq <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi_tlb_miss_log.sv
// Bench for axi_tlb_miss_log: two instances (stall mode and drop mode) share one stimulus stream.
// Each cycle every output is compared with a queue-style reference model of the logging rules.
// Directed scenarios cover the documented corner cases, then a randomized phase runs.
module tb_axi_tlb_miss_log;

   localparam int D = 4;

   logic        clk;
   logic        rst;
   logic        mv;
   logic [31:0] maddr;
   logic [3:0]  mid;
   logic        mwr;
   logic        lr;
   logic        clr;

   logic        rdy   [2];
   logic        lvld  [2];
   logic [31:0] laddr [2];
   logic [3:0]  lid   [2];
   logic        lwr   [2];
   logic [2:0]  fill  [2];
   logic [15:0] dcnt  [2];
   logic        irq   [2];

   // Reference model: ordered list of stored entries per instance ({write,id,addr}), index 0 = head.
   logic [36:0] mdat  [2][D];
   int          mcnt  [2];
   logic [15:0] mdrop [2];
   logic        mirq  [2];
   bit          mknown;

   int n_checks;
   int n_fail;

   axi_tlb_miss_log #(.AddrWidth(32), .IdWidth(4), .Depth(D), .DropWhenFull(1'b0)) dut0 (
      .clk_i(clk), .rst_i(rst),
      .miss_valid_i(mv), .miss_ready_o(rdy[0]),
      .miss_addr_i(maddr), .miss_id_i(mid), .miss_write_i(mwr),
      .log_valid_o(lvld[0]), .log_ready_i(lr),
      .log_addr_o(laddr[0]), .log_id_o(lid[0]), .log_write_o(lwr[0]),
      .fill_o(fill[0]), .drop_cnt_o(dcnt[0]), .irq_o(irq[0]), .irq_clear_i(clr)
   );

   axi_tlb_miss_log #(.AddrWidth(32), .IdWidth(4), .Depth(D), .DropWhenFull(1'b1)) dut1 (
      .clk_i(clk), .rst_i(rst),
      .miss_valid_i(mv), .miss_ready_o(rdy[1]),
      .miss_addr_i(maddr), .miss_id_i(mid), .miss_write_i(mwr),
      .log_valid_o(lvld[1]), .log_ready_i(lr),
      .log_addr_o(laddr[1]), .log_id_o(lid[1]), .log_write_o(lwr[1]),
      .fill_o(fill[1]), .drop_cnt_o(dcnt[1]), .irq_o(irq[1]), .irq_clear_i(clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Compare at the falling edge, then advance the model across the next rising edge.
   task automatic step();
      bit exp_rdy, pop, acc, push, drop, setirq;
      int cnt;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         exp_rdy = rst || (i == 1) || (mcnt[i] < D) || lr;
         check_val($sformatf("d%0d_ready", i), 64'(rdy[i]), 64'(exp_rdy));
         if (mknown) begin
            check_val($sformatf("d%0d_valid", i), 64'(lvld[i]), 64'(mcnt[i] != 0));
            check_val($sformatf("d%0d_fill", i), 64'(fill[i]), 64'(mcnt[i]));
            check_val($sformatf("d%0d_drops", i), 64'(dcnt[i]), 64'(mdrop[i]));
            check_val($sformatf("d%0d_irq", i), 64'(irq[i]), 64'(mirq[i]));
            if (mcnt[i] != 0) begin
               check_val($sformatf("d%0d_head", i), {27'd0, lwr[i], lid[i], laddr[i]}, 64'(mdat[i][0]));
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         exp_rdy = rst || (i == 1) || (mcnt[i] < D) || lr;
         if (rst) begin
            mcnt[i]  = 0;
            mdrop[i] = 16'd0;
            mirq[i]  = 1'b0;
         end else begin
            cnt    = mcnt[i];
            pop    = (cnt > 0) && lr;
            acc    = mv && exp_rdy;
            push   = acc && ((cnt < D) || pop);
            drop   = acc && !push;
            setirq = (push && cnt == 0) || drop;
            if (pop) begin
               for (int k = 0; k < D - 1; k++) mdat[i][k] = mdat[i][k+1];
               cnt--;
            end
            if (push) begin
               mdat[i][cnt] = {mwr, mid, maddr};
               cnt++;
            end
            mcnt[i] = cnt;
            if (drop && mdrop[i] != 16'hFFFF) mdrop[i] = mdrop[i] + 16'd1;
            if (setirq) mirq[i] = 1'b1;
            else if (clr) mirq[i] = 1'b0;
         end
      end
      if (rst) mknown = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; mv = 1'b0; lr = 1'b0; clr = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic push_addr(input logic [31:0] a);
      mv = 1'b1; maddr = a; mid = a[3:0]; mwr = a[0];
      step();
      mv = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_fail = 0; mknown = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mcnt[i] = 0; mdrop[i] = 16'd0; mirq[i] = 1'b0;
      end
      rst = 1'b1; mv = 1'b0; maddr = '0; mid = '0; mwr = 1'b0; lr = 1'b0; clr = 1'b0;
      step();
      step();
      rst = 1'b0;
      check_val("rst_fill", 64'(fill[1]), 64'd0);
      check_val("rst_valid", 64'(lvld[1]), 64'd0);
      check_val("rst_irq", 64'(irq[1]), 64'd0);

      // Single miss into an empty log.
      mv = 1'b1; maddr = 32'h0000_1000; mid = 4'd3; mwr = 1'b1;
      step();
      mv = 1'b0;
      check_val("single_valid", 64'(lvld[1]), 64'd1);
      check_val("single_addr", 64'(laddr[1]), 64'h1000);
      check_val("single_id", 64'(lid[1]), 64'd3);
      check_val("single_write", 64'(lwr[1]), 64'd1);
      check_val("single_fill", 64'(fill[1]), 64'd1);
      check_val("single_irq", 64'(irq[1]), 64'd1);

      // Six misses, no pops: four stored, two dropped, FIFO order on drain.
      do_reset();
      for (int k = 1; k <= 6; k++) push_addr(32'(k));
      check_val("six_fill", 64'(fill[1]), 64'd4);
      check_val("six_drops", 64'(dcnt[1]), 64'd2);
      check_val("six_stall_drops", 64'(dcnt[0]), 64'd0);
      lr = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         check_val($sformatf("six_pop%0d", k), 64'(laddr[1]), 64'(k));
         step();
      end
      lr = 1'b0;
      check_val("six_empty", 64'(lvld[1]), 64'd0);

      // Full log: simultaneous push and pop keeps fill and lands the new entry last.
      do_reset();
      for (int k = 11; k <= 14; k++) push_addr(32'(k));
      mv = 1'b1; maddr = 32'd15; lr = 1'b1;
      step();
      mv = 1'b0;
      check_val("fullpp_fill", 64'(fill[1]), 64'd4);
      check_val("fullpp_drops", 64'(dcnt[1]), 64'd0);
      check_val("fullpp_stall_fill", 64'(fill[0]), 64'd4);
      for (int k = 12; k <= 15; k++) begin
         check_val($sformatf("fullpp_pop%0d", k), 64'(laddr[1]), 64'(k));
         step();
      end
      lr = 1'b0;

      // Stall mode: full log holds off the source until the consumer pops.
      do_reset();
      for (int k = 21; k <= 24; k++) push_addr(32'(k));
      mv = 1'b1; maddr = 32'd25; lr = 1'b0;
      #1;
      check_val("stall_ready_lo", 64'(rdy[0]), 64'd0);
      step();
      step();
      lr = 1'b1;
      #1;
      check_val("stall_ready_hi", 64'(rdy[0]), 64'd1);
      step();
      mv = 1'b0; lr = 1'b0;
      check_val("stall_fill", 64'(fill[0]), 64'd4);

      // Clear coinciding with a drop loses to the set; clear alone takes effect.
      mv = 1'b1; maddr = 32'd26; clr = 1'b1;
      step();
      mv = 1'b0;
      check_val("irq_setwins", 64'(irq[1]), 64'd1);
      step();
      clr = 1'b0;
      check_val("irq_cleared", 64'(irq[1]), 64'd0);

      // Drop-counter saturation, then reset with entries stored.
      mv = 1'b1; maddr = 32'hDEAD_0000;
      for (int k = 0; k < 70000 && mdrop[1] != 16'hFFFE; k++) step();
      check_val("sat_fffe", 64'(dcnt[1]), 64'hFFFE);
      for (int k = 0; k < 3; k++) step();
      mv = 1'b0;
      check_val("sat_ffff", 64'(dcnt[1]), 64'hFFFF);
      lr = 1'b1;
      step();
      step();
      lr = 1'b0;
      check_val("sat_two_left", 64'(fill[1]), 64'd2);
      do_reset();
      check_val("rst2_fill", 64'(fill[1]), 64'd0);
      check_val("rst2_drops", 64'(dcnt[1]), 64'd0);
      check_val("rst2_irq", 64'(irq[1]), 64'd0);
      check_val("rst2_valid", 64'(lvld[1]), 64'd0);

      // Randomized traffic, occasional resets and interrupt clears.
      for (int c = 0; c < 3000; c++) begin
         rst   = ($urandom_range(0, 99) == 0);
         mv    = ($urandom_range(0, 1) == 1);
         lr    = ($urandom_range(0, 2) == 0);
         clr   = ($urandom_range(0, 7) == 0);
         maddr = $urandom;
         mid   = 4'($urandom);
         mwr   = 1'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_tlb_miss_log.md
AXI_TLB_MISS_LOG -- requirements
Module: axi_tlb_miss_log

Interface
REQ-001 Parameter AddrWidth, default 32, width of the logged untranslated input address.
REQ-002 Parameter IdWidth, default 4, width of the logged AXI ID.
REQ-003 Parameter Depth, default 4, number of log entries; SHALL be a power of two and at least 2.
REQ-004 Parameter DropWhenFull, default 1'b1; 1 means accept-and-drop when full, 0 means backpressure when full.
REQ-005 clk_i  input  1  single rising-edge clock; the block SHALL use only this clock.
REQ-006 rst_i  input  1  reset, synchronous and active-high.
REQ-007 miss_valid_i  input  1  TLB-miss record offered by the miss path.
REQ-008 miss_ready_o  output  1  miss record accepted (consumed, whether logged or dropped).
REQ-009 miss_addr_i  input  AddrWidth  untranslated address that missed.
REQ-010 miss_id_i  input  IdWidth  AXI ID of the missing transaction.
REQ-011 miss_write_i  input  1  1 = AW miss, 0 = AR miss.
REQ-012 log_valid_o  output  1  head log entry is available.
REQ-013 log_ready_i  input  1  consumer pops the head entry.
REQ-014 log_addr_o / log_id_o / log_write_o  output  AddrWidth / IdWidth / 1  head entry fields.
REQ-015 fill_o  output  $clog2(Depth)+1  current number of stored entries.
REQ-016 drop_cnt_o  output  16  saturating count of dropped misses.
REQ-017 irq_o  output  1  level interrupt, sticky.
REQ-018 irq_clear_i  input  1  single-cycle clear of irq_o.

Function
REQ-019 Storage SHALL be a circular buffer with read and write pointers of $clog2(Depth) bits that wrap from Depth-1 to 0, plus a fill counter.
REQ-020 Push condition: miss_valid_i && miss_ready_o && (fill < Depth || pop in the same cycle).
REQ-021 Pop condition: log_valid_o && log_ready_i.
REQ-022 log_valid_o SHALL equal (fill != 0).
REQ-023 The head fields SHALL be read from storage at the read pointer, with no fall-through: an entry pushed in cycle t is visible at the earliest in cycle t+1.
REQ-024 DropWhenFull=1: miss_ready_o SHALL be constantly 1.
REQ-025 DropWhenFull=0: miss_ready_o SHALL equal (fill < Depth || log_ready_i).
REQ-026 miss_ready_o SHALL NOT depend combinationally on miss_valid_i.
REQ-027 Drop event: miss_valid_i && miss_ready_o && fill == Depth && no pop in that cycle; the entry is discarded and drop_cnt_o increments by 1.
REQ-028 drop_cnt_o SHALL saturate at 16'hFFFF.
REQ-029 Simultaneous push and pop SHALL leave fill unchanged and advance both pointers, at any fill level including full and empty+1.
REQ-030 fill SHALL increment on push-only and decrement on pop-only; it SHALL never exceed Depth or underflow.
REQ-031 A pop request while empty SHALL have no effect (log_valid_o=0).
REQ-032 The head fields SHALL be held stable while log_valid_o=1 and log_ready_i=0.
REQ-033 irq set condition: a push while fill==0, or a drop event; set takes effect in the next cycle.
REQ-034 irq_clear_i SHALL clear irq_o in the next cycle.
REQ-035 If set and clear occur in the same cycle, set SHALL win.
REQ-036 irq_o SHALL remain high until cleared, regardless of pops.

Reset
REQ-037 When rst_i=1 at a clock edge, pointers, fill_o, drop_cnt_o and irq_o SHALL be 0 from the next cycle; log_valid_o SHALL therefore be 0.
REQ-038 Storage contents need not be reset; log_*_o values are don't-care while log_valid_o=0.
REQ-039 Reset mid-operation SHALL discard all stored entries and in-progress pushes and pops of that cycle, and SHALL NOT increment drop_cnt_o.
REQ-040 During reset, DropWhenFull=1 SHALL keep miss_ready_o=1; DropWhenFull=0 SHALL keep miss_ready_o=1 because the FIFO is empty.

Verification
REQ-041 Single miss addr=32'h0000_1000, id=3, write=1 into empty buffer, log_ready_i=0 -> next cycle log_valid_o=1, fields match, fill_o=1, irq_o=1.
REQ-042 Depth=4, DropWhenFull=1, push 6 misses with no pops -> fill_o=4, drop_cnt_o=2, pops return entries 1..4 in order.
REQ-043 Depth=4 full, push and pop in the same cycle -> fill_o stays 4, drop_cnt_o unchanged, new entry later emerges as 4th pop.
REQ-044 DropWhenFull=0, full, log_ready_i=0 -> miss_ready_o=0 and the source holds; log_ready_i=1 -> miss_ready_o=1 that cycle and the entry is accepted.
REQ-045 irq_o=1 with irq_clear_i and a drop in the same cycle -> irq_o stays 1; clear alone -> irq_o=0 next cycle.
REQ-046 Force drop_cnt_o to 16'hFFFE, drop 3 -> drop_cnt_o=16'hFFFF; then assert rst_i with 2 entries stored -> fill_o=0, drop_cnt_o=0, irq_o=0, log_valid_o=0 next cycle.
